// File: rtl/sfpp_add_arb.sv
// Two-port round-robin arbiter sharing one combinational FP adder (IDLE/EXEC/RESP).
// Optional macro SFPP_ARB_SUB_EN: op=1 flips the sign of b so the adder subtracts.
module sfpp_add_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req0_op,
    input  logic             req1_op,
    output logic [31:0]      add_n1,
    output logic [31:0]      add_n2,
    input  logic [31:0]      add_n3,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    input  logic             resp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_reg;
    logic              ptr_reg;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic              id_reg;
    logic [31:0]       result_reg;
    logic [CNT_W-1:0]  op_count_reg;

    logic              grant_valid;
    logic              grant_id;
    logic [1:0]        ready_vec;

    // Preferred port wins when valid, otherwise the other port takes the slot.
    assign grant_valid = (state_reg == IDLE) && (req0_valid || req1_valid);
    assign grant_id    = ptr_reg ? req1_valid : !req0_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = grant_valid && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

`ifdef SFPP_ARB_SUB_EN
    logic op_reg;
    assign add_n2 = {b_reg[31] ^ op_reg, b_reg[30:0]};
`else
    logic unused_op;
    assign unused_op = req0_op ^ req1_op;
    assign add_n2    = b_reg;
`endif

    assign add_n1     = a_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_id    = id_reg;
    assign resp_data  = result_reg;
    assign busy       = (state_reg != IDLE);
    assign op_count   = op_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            id_reg       <= 1'b0;
            result_reg   <= '0;
            op_count_reg <= '0;
`ifdef SFPP_ARB_SUB_EN
            op_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        a_reg     <= grant_id ? req1_a : req0_a;
                        b_reg     <= grant_id ? req1_b : req0_b;
                        id_reg    <= grant_id;
                        ptr_reg   <= !grant_id;
`ifdef SFPP_ARB_SUB_EN
                        op_reg    <= grant_id ? req1_op : req0_op;
`endif
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg <= add_n3;
                    state_reg  <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        op_count_reg <= op_count_reg + CNT_W'(1);
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfpp_add_arb.sv
// Directed bench for sfpp_add_arb: arbitration order, latency, back-pressure,
// mid-flight reset, counter wrap (CNT_W=4) and the SFPP_ARB_SUB_EN option.
module tb_sfpp_add_arb;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic          req0_op, req1_op;
    logic [31:0]   add_n1, add_n2, add_n3;
    logic          resp_valid, resp_id, resp_ready, busy;
    logic [31:0]   resp_data;
    logic [CW-1:0] op_count;

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] exp_cnt;

    sfpp_add_arb #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .add_n1(add_n1), .add_n2(add_n2), .add_n3(add_n3),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder model: single -> double, real add, double -> single (normals/zero only).
    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    assign add_n3 = r2s(s2r(add_n1) + s2r(add_n2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic op);
        if (p == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // Waits for a grant, checks the winner, then the EXEC and RESP cycles.
    // hold > 0 keeps resp_ready low for that many RESP cycles.
    task automatic serve(input string tag, input int p, input logic [31:0] d, input int hold);
        int n;
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_grant_seen"}, {31'd0, req0_ready || req1_ready}, 32'd1);
        if (!(req0_ready || req1_ready)) return;
        chk({tag, "_grant_port"}, {30'd0, req1_ready, req0_ready}, (p == 0) ? 32'd1 : 32'd2);
        if (hold > 0) resp_ready = 1'b0;
        @(negedge clk);
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
        chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_exec_no_resp"}, {31'd0, resp_valid}, 32'd0);
        @(negedge clk); #1;
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_resp_id"}, {31'd0, resp_id}, p[31:0]);
        chk({tag, "_resp_data"}, resp_data, d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_hold_data"}, resp_data, d);
            chk({tag, "_hold_id"}, {31'd0, resp_id}, p[31:0]);
            chk({tag, "_hold_no_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
            chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold_count"}, {28'd0, op_count}, {28'd0, exp_cnt});
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 4'd1;
        chk({tag, "_count"}, {28'd0, op_count}, {28'd0, exp_cnt});
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_op = 1'b0; req1_op = 1'b0;
        resp_ready = 1'b1;
        exp_cnt = '0;

        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_count", {28'd0, op_count}, 32'd0);
        chk("rst_n1", add_n1, 32'd0);
        chk("rst_n2", add_n2, 32'd0);
        chk("rst_data", resp_data, 32'd0);

        // 5.0 + 2.0 = 7.0
        set_req(0, 32'h40A00000, 32'h40000000, 1'b0);
        serve("basic", 0, 32'h40E00000, 0);

        // Both valid from reset: port 0 first, then port 1.
        do_reset();
        set_req(0, 32'h3F000000, 32'h3E800000, 1'b0);
        set_req(1, 32'h3F000000, 32'h3F400000, 1'b0);
        serve("rr_a0", 0, 32'h3F400000, 0);
        serve("rr_a1", 1, 32'h3FA00000, 0);
        // Lone port-0 grant points at port 1, so the next contention goes 1 then 0.
        set_req(0, 32'h40A00000, 32'h40000000, 1'b0);
        serve("rr_solo", 0, 32'h40E00000, 0);
        set_req(0, 32'h3F000000, 32'h3E800000, 1'b0);
        set_req(1, 32'h3F000000, 32'h3F400000, 1'b0);
        serve("rr_b1", 1, 32'h3FA00000, 0);
        serve("rr_b0", 0, 32'h3F400000, 0);

        // op bit: subtract when the option is built in, ignored otherwise.
        set_req(0, 32'h40A00000, 32'h40000000, 1'b1);
`ifdef SFPP_ARB_SUB_EN
        serve("op_p0", 0, 32'h40400000, 0);
`else
        serve("op_p0", 0, 32'h40E00000, 0);
`endif
        set_req(1, 32'h41200000, 32'h41700000, 1'b1);
`ifdef SFPP_ARB_SUB_EN
        serve("op_p1", 1, 32'hC0A00000, 0);
`else
        serve("op_p1", 1, 32'h41C80000, 0);
`endif

        // Back-pressure: port 1 waits while the port-0 response is stalled.
        set_req(0, 32'h3F000000, 32'h3E800000, 1'b0);
        set_req(1, 32'h40A00000, 32'h40000000, 1'b0);
        serve("hold", 0, 32'h3F400000, 5);
        serve("after_hold", 1, 32'h40E00000, 0);

        // Reset during EXEC discards the operation.
        set_req(0, 32'h40A00000, 32'h40000000, 1'b0);
        #1;
        chk("mid_grant", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_resp", {31'd0, resp_valid}, 32'd0);
        chk("mid_count", {28'd0, op_count}, 32'd0);
        @(negedge clk); #1;
        chk("mid_resp2", {31'd0, resp_valid}, 32'd0);
        exp_cnt = '0;
        set_req(0, 32'h3F000000, 32'h3E800000, 1'b0);
        set_req(1, 32'h3F000000, 32'h3F400000, 1'b0);
        serve("post_rst0", 0, 32'h3F400000, 0);
        serve("post_rst1", 1, 32'h3FA00000, 0);

        // 16 completions on a 4-bit counter wrap it back to zero.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
            serve("wrap", 0, 32'h40000000, 0);
            if (i == 14) chk("wrap_all_ones", {28'd0, op_count}, 32'd15);
        end
        chk("wrap_zero", {28'd0, op_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
